// File: rtl/cnt_digits_seg7_if.sv
// Control and display bundle of the multi-digit tick counter.
// The testbench drives through master; the counter uses slave.
interface cnt_digits_seg7_if #(
    parameter int unsigned DIGITS = 2
);
    logic                      en;
    logic                      up_dn;
    logic                      clr;
    logic                      load;
    logic [4*DIGITS-1:0]       load_val;
    logic [4*DIGITS-1:0]       digit_val;
    logic                      tick_out;
    logic                      carry_out;
    logic [DIGITS-1:0][7:0]    seg7led;

    modport master (
        output en, up_dn, clr, load, load_val,
        input  digit_val, tick_out, carry_out, seg7led
    );

    modport slave (
        input  en, up_dn, clr, load, load_val,
        output digit_val, tick_out, carry_out, seg7led
    );
endinterface

// File: rtl/cnt_digits_seg7.sv
// Prescaled multi-digit up/down counter with carry chain and registered
// active-low 7-segment drive (leading-zero blanking, heartbeat dp).
module cnt_digits_seg7 #(
    parameter int unsigned FREQUENCY = 50_000_000,
    parameter int unsigned TICK_HZ   = 1,
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned RADIX     = 10,
    parameter int unsigned BLANK_LZ  = 0
) (
    input  logic               clk,
    input  logic               n_rst,
    cnt_digits_seg7_if.slave   cnt_if
);
    localparam int unsigned DIV  = FREQUENCY / TICK_HZ;
    localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned HALF = DIV / 2;
    localparam logic [3:0]  RMAX = 4'(RADIX - 1);

    // Hex glyphs, active-low, bit0 = a .. bit6 = g.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
            4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
            4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
            4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
        endcase
        return g;
    endfunction

    function automatic logic [DIGITS-1:0][7:0] seg_reset();
        logic [DIGITS-1:0][7:0] s;
        for (int i = 0; i < int'(DIGITS); i++)
            s[i] = (i == 0 || BLANK_LZ == 0) ? 8'hC0 : 8'hFF;
        return s;
    endfunction

    localparam logic [DIGITS-1:0][7:0] SEG_RST = seg_reset();

    logic [PW-1:0]              pre_q, pre_d;
    logic                       tick_q, tick_d;
    logic                       carry_q, carry_d;
    logic [DIGITS-1:0][3:0]     dig_q, dig_d;
    logic [DIGITS-1:0][7:0]     seg_q, seg_d;
    logic                       lower_term;
    logic                       hz;
    logic [3:0]                 fld;

    // Prescaler, tick generation and digit chain; clr beats load beats count.
    always_comb begin
        pre_d      = pre_q;
        tick_d     = 1'b0;
        carry_d    = 1'b0;
        dig_d      = dig_q;
        lower_term = 1'b1;
        fld        = 4'd0;

        if (cnt_if.en)
            pre_d = (pre_q == PW'(DIV - 1)) ? '0 : pre_q + PW'(1);
        tick_d = cnt_if.en & (pre_q == PW'(DIV - 1));

        if (cnt_if.clr) begin
            pre_d  = '0;
            tick_d = 1'b0;
            dig_d  = '0;
        end else if (cnt_if.load) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                fld      = cnt_if.load_val[4*i +: 4];
                dig_d[i] = (fld > RMAX) ? RMAX : fld;
            end
        end else if (cnt_if.en && tick_q) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (lower_term)
                    dig_d[i] = cnt_if.up_dn ? ((dig_q[i] == RMAX) ? 4'd0 : dig_q[i] + 4'd1)
                                            : ((dig_q[i] == 4'd0) ? RMAX : dig_q[i] - 4'd1);
                lower_term = lower_term & (dig_q[i] == (cnt_if.up_dn ? RMAX : 4'd0));
            end
            carry_d = lower_term;
        end
    end

    // Segment image of the current digits; dp tracks the prescaler phase it will show with.
    always_comb begin
        seg_d = '0;
        hz    = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            hz            = hz & (dig_q[i] == 4'd0);
            seg_d[i][6:0] = (BLANK_LZ != 0 && i != 0 && hz) ? 7'h7F : glyph(dig_q[i]);
            seg_d[i][7]   = 1'b1;
        end
        seg_d[0][7] = ~(cnt_if.en & (pre_d < PW'(HALF)));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
            dig_q   <= '0;
            seg_q   <= SEG_RST;
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            carry_q <= carry_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
        end
    end

    assign cnt_if.digit_val = dig_q;
    assign cnt_if.tick_out  = tick_q;
    assign cnt_if.carry_out = carry_q;
    assign cnt_if.seg7led   = seg_q;
endmodule

// File: doc/cnt_digits_seg7.md
# cnt_digits_seg7

Parametrised multi-digit tick counter with built-in prescaler and registered 7-segment drive. It is the successor to the separate one-second counter, per-digit counters and decoder currently instanced in the top level. It adds several capabilities:

- configurable digit count and radix
- a true carry/borrow chain across digits
- up/down counting, pause, synchronous clear and parallel load
- leading-zero blanking and a heartbeat decimal point

It sits directly between the board clock/buttons and the 7-segment pins.

## Interface
Parameters:
- FREQUENCY, 50*10**6, input clock frequency in Hz
- TICK_HZ, 1, count rate in Hz; DIV = FREQUENCY/TICK_HZ, must be >= 2
- DIGITS, 2, number of digits, 1..8
- RADIX, 10, per-digit modulus, 2..16
- BLANK_LZ, 0, 1 = blank leading zero digits

Ports:
- clk  in  1  clock
- n_rst  in  1  reset; one clock; reset is asynchronous and active-low
- en  in  1  1 = run, 0 = pause (prescaler and digits hold)
- up_dn  in  1  1 = count up, 0 = count down
- clr  in  1  synchronous clear of digits and prescaler
- load  in  1  synchronous load of load_val into digits
- load_val  in  4*DIGITS  packed digits, digit 0 in bits [3:0]
- digit_val  out  4*DIGITS  current digit values, same packing
- tick_out  out  1  one-cycle pulse every DIV enabled cycles
- carry_out  out  1  one-cycle pulse on full-width wrap (up or down)
- seg7led  out  [7:0] x DIGITS  active-low segments, bit0=a..bit6=g, bit7=dp

## Operation
- Prescaler `pre` has width $clog2(DIV) and counts 0..DIV-1 while en=1. It wraps to 0 after DIV-1 and holds while en=0.
- tick_out is registered. It is 1 in the cycle after `pre` was DIV-1 with en=1.
- Priority per cycle is clr > load > (en & tick_out).
  - clr: digits <= 0, pre <= 0, tick_out and carry_out <= 0 next cycle.
  - load: each digit <= min(load_val field, RADIX-1). pre is unaffected. A tick in the same cycle is discarded.
  - count (tick_out=1, en=1): digit i steps when all lower digits are at the terminal value.
    - Up: terminal value is RADIX-1; the digit steps +1 and wraps to 0.
    - Down: terminal value is 0; the digit steps -1 and wraps to RADIX-1.
    - Digit 0 always steps.
- carry_out is registered. It is 1 for one cycle, coincident with the digit update, when every digit was terminal before the step: all RADIX-1 going to all 0 (up), or all 0 going to all RADIX-1 (down).
- up_dn is sampled in the tick cycle. A change between ticks is legal.
- Decoder is the standard hex 0-F glyph set, active-low. Digits never hold a value >= RADIX.
- BLANK_LZ=1: a digit i>0 is blanked (segments 7'h7F) when it and all higher digits are 0. Digit 0 is never blanked.
- dp: digit 0 dp is lit (0) while en=1 and pre < DIV/2. All other dp bits are 1.

## Timing
- Reset (n_rst=0, asynchronous) forces:
  - pre=0, digits=0, tick_out=0, carry_out=0
  - seg7led digit 0 = 8'hC0 ("0", dp off)
  - other digits = 8'hC0, or 8'hFF if BLANK_LZ=1
- After reset release with en=1, the first tick_out is high in cycle DIV (reset release edge = cycle 0 → pre reaches DIV-1 at cycle DIV-1).
- digit_val and carry_out update on the clock edge that ends the tick_out cycle (1 cycle after tick_out).
- seg7led is registered from digit_val, so it updates 1 cycle after digit_val (2 cycles after tick_out).
- load/clr affect digit_val 1 cycle later and seg7led 2 cycles later.
- en falling mid-period freezes pre. On re-enable, counting resumes from the frozen value, with no lost or extra tick.
- Reset asserted mid-operation clears all state immediately. No partial carry survives.

## Test plan
Parameters for all scenarios unless noted: FREQUENCY=10, TICK_HZ=1 (DIV=10), DIGITS=2, RADIX=10.
- Reset release, en=1, up_dn=1, 25 cycles:
  - tick_out high at cycles 10 and 20 only
  - digit_val=8'h01 from cycle 11 and 8'h02 from cycle 21
  - seg7led[0]=8'hF9 (dp off) / 8'h79 (dp on) from cycle 12, with dp following pre < 5
- load_val=8'h99, then one tick up:
  - digit_val 8'h99 → 8'h00
  - carry_out pulses for exactly 1 cycle, coincident with the update
- load_val=8'h00, up_dn=0, one tick:
  - digit_val=8'h99 and carry_out pulses
  - with load_val=8'h10, one tick gives 8'h09 and no carry_out
- load_val=8'hFC (out of range) → digit_val=8'h99. Assert clr and load together → digit_val=8'h00 and pre=0.
- en low at pre=4 for 7 cycles, then high:
  - the next tick_out occurs 6 enabled cycles later
  - tick_out stays 0 while paused
- BLANK_LZ=1, RADIX=16, DIGITS=3, load 12'h00A:
  - seg7led[2]=seg7led[1]=8'hFF, seg7led[0] shows "A" (8'h88 or 8'h08)
  - assert n_rst mid-count → all outputs return to reset values asynchronously
